// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order-commit reorder buffer with writeback, forwarding and mispredict flush
// Optional feature macro ROB_WB_BYPASS_EN: commit and forward straight from same-cycle writebacks.
module reorder_buffer #(
  parameter int ROB_SIZE_BITS = 3,
  parameter int WB_PORTS      = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              rdy_in,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  output logic [ROB_SIZE_BITS-1:0]          issue_id,
  input  logic [4:0]                        issue_rd,
  input  logic                              issue_writes_rd,
  input  logic [31:0]                       issue_predicted_PC,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS*ROB_SIZE_BITS-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]            wb_val,
  input  logic [WB_PORTS*32-1:0]            wb_resulting_PC,
  input  logic [ROB_SIZE_BITS-1:0]          query_id,
  output logic                              query_ready,
  output logic [31:0]                       query_val,
  output logic                              rf_is_writing_rd,
  output logic [4:0]                        rf_rd_reg_id,
  output logic [31:0]                       rf_rd_val,
  output logic [ROB_SIZE_BITS-1:0]          commit_id,
  output logic                              flush_pipeline,
  output logic [31:0]                       reset_PC_to,
  output logic [ROB_SIZE_BITS:0]            count
);
  localparam int DEPTH = 1 << ROB_SIZE_BITS;
  localparam logic [ROB_SIZE_BITS:0]   FULL_COUNT = (ROB_SIZE_BITS+1)'(DEPTH);
  localparam logic [ROB_SIZE_BITS:0]   CNT_ONE    = (ROB_SIZE_BITS+1)'(1);
  localparam logic [ROB_SIZE_BITS-1:0] ID_ONE     = ROB_SIZE_BITS'(1);

  typedef enum logic [1:0] {E_EMPTY, E_ISSUED, E_DONE} entry_state_t;

  entry_state_t             r_state   [DEPTH];
  logic [4:0]               r_rd      [DEPTH];
  logic                     r_writes  [DEPTH];
  logic [31:0]              r_pred_pc [DEPTH];
  logic [31:0]              r_val     [DEPTH];
  logic [31:0]              r_res_pc  [DEPTH];
  logic [ROB_SIZE_BITS-1:0] r_head;
  logic [ROB_SIZE_BITS-1:0] r_tail;
  logic [ROB_SIZE_BITS:0]   r_count;
  logic                     r_rf_wr;
  logic [4:0]               r_rf_rd;
  logic [31:0]              r_rf_val;
  logic [ROB_SIZE_BITS-1:0] r_commit_id;
  logic                     r_flush;
  logic [31:0]              r_reset_pc;

  logic [ROB_SIZE_BITS-1:0] w_wb_id [WB_PORTS];
  logic                     w_issue_fire;
  logic                     w_commit;
  logic                     w_mispredict;
  logic [31:0]              w_c_val;
  logic [31:0]              w_c_pc;
  logic                     w_q_ready;
  logic [31:0]              w_q_val;

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      w_wb_id[k] = wb_id[k*ROB_SIZE_BITS +: ROB_SIZE_BITS];
    end
  end

  assign issue_ready  = (r_count < FULL_COUNT) && !r_flush;
  assign w_issue_fire = issue_valid && issue_ready;

  // Channels are scanned high-to-low so the lowest matching index is the last, winning assignment.
  always_comb begin
    w_commit  = (r_state[r_head] == E_DONE);
    w_c_val   = r_val[r_head];
    w_c_pc    = r_res_pc[r_head];
    w_q_ready = (r_state[query_id] == E_DONE);
    w_q_val   = r_val[query_id];
`ifdef ROB_WB_BYPASS_EN
    for (int k = WB_PORTS-1; k >= 0; k--) begin
      if (wb_valid[k] && r_state[r_head] == E_ISSUED && w_wb_id[k] == r_head) begin
        w_commit = 1'b1;
        w_c_val  = wb_val[k*32 +: 32];
        w_c_pc   = wb_resulting_PC[k*32 +: 32];
      end
      if (wb_valid[k] && r_state[query_id] == E_ISSUED && w_wb_id[k] == query_id) begin
        w_q_ready = 1'b1;
        w_q_val   = wb_val[k*32 +: 32];
      end
    end
`endif
    w_mispredict = w_commit && (w_c_pc != r_pred_pc[r_head]);
  end

  assign query_ready = w_q_ready;
  assign query_val   = w_q_ready ? w_q_val : 32'd0;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i]   <= E_EMPTY;
        r_rd[i]      <= '0;
        r_writes[i]  <= 1'b0;
        r_pred_pc[i] <= '0;
        r_val[i]     <= '0;
        r_res_pc[i]  <= '0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rf_wr     <= 1'b0;
      r_rf_rd     <= '0;
      r_rf_val    <= '0;
      r_commit_id <= '0;
      r_flush     <= 1'b0;
      r_reset_pc  <= '0;
    end else if (!rdy_in) begin
      r_rf_wr <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_rf_wr <= 1'b0;
      r_flush <= 1'b0;
      if (w_issue_fire) begin
        r_state[r_tail]   <= E_ISSUED;
        r_rd[r_tail]      <= issue_rd;
        r_writes[r_tail]  <= issue_writes_rd;
        r_pred_pc[r_tail] <= issue_predicted_PC;
        r_tail            <= r_tail + ID_ONE;
      end
      for (int k = WB_PORTS-1; k >= 0; k--) begin
        if (wb_valid[k] && r_state[w_wb_id[k]] == E_ISSUED) begin
          r_state[w_wb_id[k]]  <= E_DONE;
          r_val[w_wb_id[k]]    <= wb_val[k*32 +: 32];
          r_res_pc[w_wb_id[k]] <= wb_resulting_PC[k*32 +: 32];
        end
      end
      if (w_commit) begin
        r_state[r_head] <= E_EMPTY;
        r_head          <= r_head + ID_ONE;
        r_rf_wr         <= r_writes[r_head] && (r_rd[r_head] != 5'd0);
        r_rf_rd         <= r_rd[r_head];
        r_rf_val        <= w_c_val;
        r_commit_id     <= r_head;
      end
      case ({w_issue_fire, w_commit})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A mispredict discards everything else done at this edge except the commit write itself.
      if (w_mispredict) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_state[i] <= E_EMPTY;
        end
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_flush    <= 1'b1;
        r_reset_pc <= w_c_pc;
      end
    end
  end

  assign issue_id         = r_tail;
  assign count            = r_count;
  assign rf_is_writing_rd = r_rf_wr;
  assign rf_rd_reg_id     = r_rf_rd;
  assign rf_rd_val        = r_rf_val;
  assign commit_id        = r_commit_id;
  assign flush_pipeline   = r_flush;
  assign reset_PC_to      = r_reset_pc;
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised in-order-commit reorder buffer. It sits between the issue stage and the register file, and is the successor to the combined central schedule unit. It allocates entries at issue and accepts results from a configurable number of writeback channels. It answers operand-forwarding queries, commits results to the register file in program order, and raises a pipeline flush with the corrected PC when a committed instruction's resulting PC differs from its predicted PC.

## Interface
Parameters:
- `ROB_SIZE_BITS`, default 3: entry id width; depth `DEPTH = 2**ROB_SIZE_BITS`.
- `WB_PORTS`, default 2: number of writeback channels (ALU, memory operator, ...).

Ports (clock and reset first):
- `clk_in` in 1: system clock; everything sampled on the rising edge.
- `rst_n_in` in 1: reset, synchronous, active-low.
- `rdy_in` in 1: when low, state is frozen (pause).
- `issue_valid` in 1: allocate the tail entry this cycle.
- `issue_ready` out 1: `count < DEPTH && !flush_pipeline`; combinational.
- `issue_id` out ROB_SIZE_BITS: tail id, i.e. the id the next issued instruction receives.
- `issue_rd` in 5: destination register.
- `issue_writes_rd` in 1: the instruction writes rd.
- `issue_predicted_PC` in 32: PC predicted to follow this instruction.
- `wb_valid` in WB_PORTS: per-channel result valid.
- `wb_id` in WB_PORTS*ROB_SIZE_BITS: entry id; channel k occupies bits [k*ROB_SIZE_BITS +: ROB_SIZE_BITS].
- `wb_val` in WB_PORTS*32: result value; channel k occupies bits [k*32 +: 32].
- `wb_resulting_PC` in WB_PORTS*32: actual next PC; packed the same way as `wb_val`.
- `query_id` in ROB_SIZE_BITS: entry to look up.
- `query_ready` out 1: the entry is DONE; combinational.
- `query_val` out 32: stored value; combinational, 0 unless DONE.
- `rf_is_writing_rd` out 1: registered single-cycle commit write strobe.
- `rf_rd_reg_id` out 5: registered commit destination.
- `rf_rd_val` out 32: registered commit value.
- `commit_id` out ROB_SIZE_BITS: registered id of the last committed entry.
- `flush_pipeline` out 1: registered single-cycle flush pulse.
- `reset_PC_to` out 32: registered corrected PC; valid while `flush_pipeline` is high.
- `count` out ROB_SIZE_BITS+1: occupied entries.

## Operation
- Per-entry state is EMPTY, ISSUED or DONE. Each entry also stores rd, writes_rd, predicted_PC, val and resulting_PC.
- **Issue:** when `issue_valid && issue_ready`, entry[tail] becomes ISSUED, tail increments modulo DEPTH and count increments. Issue when not ready is ignored.
- **Writeback:** for each channel with `wb_valid`, if entry[wb_id] is ISSUED it becomes DONE and stores val and resulting_PC.
  - A writeback to an EMPTY or DONE entry is ignored.
  - When several channels target the same id in the same cycle, the lowest channel index wins.
- **Commit:** at most one entry per cycle. If entry[head] is DONE:
  - `rf_is_writing_rd` is set to `writes_rd && rd != 0`; `rf_rd_reg_id`, `rf_rd_val` and `commit_id` are loaded.
  - The entry becomes EMPTY, head increments and count decrements.
- **Mispredict:** if the committing entry has `resulting_PC != predicted_PC`:
  - Its rd write still occurs.
  - `flush_pipeline` is set to 1 and `reset_PC_to` is set to resulting_PC.
  - At that same edge every entry becomes EMPTY, head = tail = 0 and count = 0. Issue and writebacks in that cycle are discarded.
- **Simultaneous events:** issue, writeback and commit in one cycle are independent; count changes by (+issue − commit).
- **Wrap-around:** head and tail wrap modulo DEPTH. Full is `count == DEPTH`; empty is `count == 0`.

## Timing
- **Reset** (`rst_n_in` low at an edge): all entries EMPTY, head = tail = count = 0, and every registered output is 0. After reset, `issue_ready` = 1 and `issue_id` = 0.
- **Pause:** at an edge with `rdy_in` low, all state is held and `rf_is_writing_rd` and `flush_pipeline` are cleared to 0, so a strobe is never repeated.
- **Writeback to commit latency:** a writeback sampled at edge N sets DONE; the commit happens at edge N+1, with strobe outputs visible in the cycle after N+1. See Configuration for the bypass variant.
- **Strobe width:** `flush_pipeline` and `rf_is_writing_rd` are high for exactly one cycle per event.
- **During flush:** `issue_ready` is 0 during the `flush_pipeline` cycle.
- Reset takes priority over pause; pause takes priority over all other activity.

## Configuration
- `ROB_WB_BYPASS_EN` defined: if entry[head] is ISSUED and a valid writeback (lowest channel index) targets head at edge N, the entry commits at edge N using the writeback data, with the same mispredict check. `query_ready`/`query_val` also forward matching in-flight writebacks combinationally. Writeback-to-commit latency becomes 0 edges.
- `ROB_WB_BYPASS_EN` undefined: commit only from stored DONE state; query returns stored state only.

## Test plan
- **Reset:** reset, then issue 3 entries (rd 1, 2, 3), then write back ids 2, 1, 0 with values 0x30, 0x20, 0x10 and matching PCs. Required: commits in order rd 1 = 0x10, rd 2 = 0x20, rd 3 = 0x30, with one strobe each and `count` returning to 0.
- **Full:** issue DEPTH entries. Required: `issue_ready` = 0 and an extra `issue_valid` is ignored. Write back and commit id 0, then issue in the same cycle as a further commit: `count` stays at DEPTH−1, and tail wraps to id 0.
- **Mispredict:** id 1 is issued with predicted 0x104 and written back with resulting 0x200. Required: id 1's rd is written, `flush_pipeline` is high for 1 cycle with `reset_PC_to` = 0x200, `count` = 0 and `issue_id` = 0 afterward. Writebacks to the flushed id 2 are ignored.
- **Channel conflict:** both channels target id 0 with values 0xA (channel 0) and 0xB (channel 1). Required: committed value 0xA; a later writeback to the DONE id is ignored.
- **rd = 0 and pause:** an entry with rd = 0 commits with `rf_is_writing_rd` = 0. Drop `rdy_in` for 3 cycles while the head is DONE: no commit occurs, and exactly one strobe fires after `rdy_in` returns.
- **Bypass** (`ROB_WB_BYPASS_EN` only): a head writeback at edge N gives the strobe in the cycle after edge N. Without the macro, the strobe appears in the cycle after N+1.
